// File: rtl/ram_16x4_bist.sv
// March-style self-test initiator for the 16x4 register-file RAM: W0/R0 ascending, W1/R1 descending.
// Optional BIST_ERR_COUNT_EN: keep running after mismatches and count them instead of stopping early.
module ram_16x4_bist #(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 4,
  parameter logic [DATA_W-1:0] PATTERN = 4'b0101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef BIST_ERR_COUNT_EN
  ,
  output logic [ADDR_W:0]   err_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_R0   = 3'd2,
    S_W1   = 3'd3,
    S_R1   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_FIRST = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
`ifdef BIST_ERR_COUNT_EN
  localparam logic [ADDR_W:0]   ERR_ZERO   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ERR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ERR_MAX    = {(ADDR_W+1){1'b1}};
`endif

  // Expected read word for the read phase currently being presented.
  function automatic logic [DATA_W-1:0] phase_expect(input state_t st);
    return (st == S_R1) ? ~PATTERN : PATTERN;
  endfunction

  function automatic logic is_read_phase(input state_t st);
    return (st == S_R0) || (st == S_R1);
  endfunction

  state_t            state;
  state_t            state_s;
  logic              start_r;
  logic              failed_r;
  logic              failed_s;
  logic              busy_s;
  logic              done_s;
  logic              pass_s;
  logic [ADDR_W-1:0] fail_addr_s;
  logic [DATA_W-1:0] fail_data_s;
  logic              mem_we_s;
  logic              mem_re_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              mismatch_s;
  logic              finish_s;
  logic              finish_pass_s;
`ifdef BIST_ERR_COUNT_EN
  logic [ADDR_W:0]   err_s;
`endif

  // Read data is compared in the cycle its address is on the bus.
  assign mismatch_s = is_read_phase(state) && (mem_rdata != phase_expect(state));

  // Next-state and next-output computation for the march sequencer.
  always_comb begin
    state_s       = state;
    busy_s        = busy;
    done_s        = done;
    pass_s        = pass;
    fail_addr_s   = fail_addr;
    fail_data_s   = fail_data;
    failed_s      = failed_r;
    mem_we_s      = mem_we;
    mem_re_s      = mem_re;
    mem_addr_s    = mem_addr;
    mem_wdata_s   = mem_wdata;
    finish_s      = 1'b0;
    finish_pass_s = 1'b0;
`ifdef BIST_ERR_COUNT_EN
    err_s         = err_count;
`endif

    if (mismatch_s && !failed_r) begin
      failed_s    = 1'b1;
      fail_addr_s = mem_addr;
      fail_data_s = mem_rdata;
    end else begin
      failed_s    = failed_r;
    end

`ifdef BIST_ERR_COUNT_EN
    if (mismatch_s && (err_count != ERR_MAX)) begin
      err_s = err_count + ERR_ONE;
    end else begin
      err_s = err_count;
    end
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start_r) begin
          state_s     = S_W0;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          pass_s      = 1'b0;
          fail_addr_s = ADDR_FIRST;
          fail_data_s = DATA_ZERO;
          failed_s    = 1'b0;
          mem_we_s    = 1'b1;
          mem_re_s    = 1'b0;
          mem_addr_s  = ADDR_FIRST;
          mem_wdata_s = PATTERN;
`ifdef BIST_ERR_COUNT_EN
          err_s       = ERR_ZERO;
`endif
        end else begin
          state_s = state;
        end
      end
      S_W0: begin
        if (mem_addr == ADDR_LAST) begin
          state_s     = S_R0;
          mem_we_s    = 1'b0;
          mem_re_s    = 1'b1;
          mem_addr_s  = ADDR_FIRST;
          mem_wdata_s = DATA_ZERO;
        end else begin
          mem_addr_s  = mem_addr + ADDR_ONE;
        end
      end
      S_R0: begin
`ifndef BIST_ERR_COUNT_EN
        if (mismatch_s) begin
          finish_s      = 1'b1;
          finish_pass_s = 1'b0;
        end else
`endif
        if (mem_addr == ADDR_LAST) begin
          state_s     = S_W1;
          mem_we_s    = 1'b1;
          mem_re_s    = 1'b0;
          mem_addr_s  = ADDR_LAST;
          mem_wdata_s = ~PATTERN;
        end else begin
          mem_addr_s  = mem_addr + ADDR_ONE;
        end
      end
      S_W1: begin
        if (mem_addr == ADDR_FIRST) begin
          state_s     = S_R1;
          mem_we_s    = 1'b0;
          mem_re_s    = 1'b1;
          mem_addr_s  = ADDR_LAST;
          mem_wdata_s = DATA_ZERO;
        end else begin
          mem_addr_s  = mem_addr - ADDR_ONE;
        end
      end
      S_R1: begin
`ifndef BIST_ERR_COUNT_EN
        if (mismatch_s) begin
          finish_s      = 1'b1;
          finish_pass_s = 1'b0;
        end else
`endif
        if (mem_addr == ADDR_FIRST) begin
          finish_s      = 1'b1;
`ifdef BIST_ERR_COUNT_EN
          finish_pass_s = (err_s == ERR_ZERO);
`else
          finish_pass_s = 1'b1;
`endif
        end else begin
          mem_addr_s    = mem_addr - ADDR_ONE;
        end
      end
      default: begin
        state_s     = S_IDLE;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        pass_s      = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_addr_s  = ADDR_FIRST;
        mem_wdata_s = DATA_ZERO;
      end
    endcase

    if (finish_s) begin
      state_s     = S_DONE;
      busy_s      = 1'b0;
      done_s      = 1'b1;
      pass_s      = finish_pass_s;
      mem_we_s    = 1'b0;
      mem_re_s    = 1'b0;
      mem_addr_s  = ADDR_FIRST;
      mem_wdata_s = DATA_ZERO;
    end else begin
      state_s     = state_s;
    end
  end

  // State and output registers; start is registered so a run begins one edge after it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      start_r   <= 1'b0;
      failed_r  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= ADDR_FIRST;
      fail_data <= DATA_ZERO;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= ADDR_FIRST;
      mem_wdata <= DATA_ZERO;
`ifdef BIST_ERR_COUNT_EN
      err_count <= ERR_ZERO;
`endif
    end else begin
      state     <= state_s;
      start_r   <= start;
      failed_r  <= failed_s;
      busy      <= busy_s;
      done      <= done_s;
      pass      <= pass_s;
      fail_addr <= fail_addr_s;
      fail_data <= fail_data_s;
      mem_we    <= mem_we_s;
      mem_re    <= mem_re_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
`ifdef BIST_ERR_COUNT_EN
      err_count <= err_s;
`endif
    end
  end

endmodule

// File: tb/tb_ram_16x4_bist.sv
// Bench for ram_16x4_bist: behavioural 16x4 RAM with stuck-at faults, bus and result scoreboards.
module tb_ram_16x4_bist;

  localparam logic [3:0] PAT = 4'b0101;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, pass, mem_we, mem_re;
  logic [3:0] fail_addr, fail_data, mem_addr, mem_wdata, mem_rdata, rd_val;
`ifdef BIST_ERR_COUNT_EN
  logic [4:0] err_count;
`endif

  logic [3:0] ram    [16];
  logic [3:0] stuck1 [16];
  logic [3:0] stuck0 [16];

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [3:0] wdata;
  } bus_t;

  typedef struct {
    logic       pass;
    logic [3:0] faddr;
    logic [3:0] fdata;
    int         errs;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bus_t mon_b;
  res_t mon_r;
  int   exp_lat;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic done_d = 1'b0;

  ram_16x4_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef BIST_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
  end

  assign rd_val    = (ram[mem_addr] | stuck1[mem_addr]) & ~stuck0[mem_addr];
  assign mem_rdata = (mem_re === 1'b1) ? rd_val : 4'bz;

  // Reference march: builds the expected bus sequence and final result from the fault map.
  function automatic void model_run();
    bus_t       b;
    res_t       r;
    logic [3:0] m [16];
    logic [3:0] got, want;
    int         steps;
    logic       stop;
    r.pass = 1'b1; r.faddr = 4'd0; r.fdata = 4'd0; r.errs = 0;
    steps = 0; stop = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 16; k++) begin
        if (!stop) begin
          b.addr  = (ph < 2) ? 4'(k) : 4'(15 - k);
          b.we    = (ph == 0) || (ph == 2);
          b.re    = !b.we;
          b.wdata = (ph == 0) ? PAT : ((ph == 2) ? ~PAT : 4'd0);
          bus_q.push_back(b);
          steps++;
          if (b.we) begin
            m[b.addr] = b.wdata;
          end else begin
            want = (ph == 1) ? PAT : ~PAT;
            got  = (m[b.addr] | stuck1[b.addr]) & ~stuck0[b.addr];
            if (got !== want) begin
              if (r.errs < 31) r.errs++;
              if (r.pass) begin
                r.pass = 1'b0; r.faddr = b.addr; r.fdata = got;
              end
`ifndef BIST_ERR_COUNT_EN
              stop = 1'b1;
`endif
            end
          end
        end
      end
    end
    res_q.push_back(r);
    exp_lat = steps;
  endfunction

  // Bus monitor and result scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if ((mem_we & mem_re) !== 1'b0) begin
        n_err++; $display("FAIL we_re_exclusive: got we=%b re=%b, want not both 1", mem_we, mem_re);
      end
      if (busy === 1'b1) begin
        n_vec++;
        if (bus_q.size() == 0) begin
          n_err++; $display("FAIL bus_extra: got busy cycle addr=%0d, want no more busy cycles", mem_addr);
        end else begin
          mon_b = bus_q.pop_front();
          if (mem_we !== mon_b.we || mem_re !== mon_b.re || mem_addr !== mon_b.addr ||
              (mon_b.we && (mem_wdata !== mon_b.wdata))) begin
            n_err++;
            $display("FAIL bus_seq: got we=%b re=%b addr=%0d wdata=%b, want we=%b re=%b addr=%0d wdata=%b",
                     mem_we, mem_re, mem_addr, mem_wdata, mon_b.we, mon_b.re, mon_b.addr, mon_b.wdata);
          end
        end
      end else begin
        n_vec++;
        if ({mem_we, mem_re, mem_addr, mem_wdata} !== 10'd0) begin
          n_err++;
          $display("FAIL bus_idle: got we=%b re=%b addr=%0d wdata=%b, want all 0", mem_we, mem_re, mem_addr, mem_wdata);
        end
      end
      if (done === 1'b1 && done_d !== 1'b1) begin
        n_vec++;
        if (res_q.size() == 0) begin
          n_err++; $display("FAIL result_extra: got done rise, want none");
        end else begin
          mon_r = res_q.pop_front();
          if (pass !== mon_r.pass || fail_addr !== mon_r.faddr || fail_data !== mon_r.fdata) begin
            n_err++;
            $display("FAIL result: got pass=%b fail_addr=%0d fail_data=%b, want pass=%b fail_addr=%0d fail_data=%b",
                     pass, fail_addr, fail_data, mon_r.pass, mon_r.faddr, mon_r.fdata);
          end
`ifdef BIST_ERR_COUNT_EN
          n_vec++;
          if (err_count !== 5'(mon_r.errs)) begin
            n_err++; $display("FAIL err_count: got %0d, want %0d", err_count, mon_r.errs);
          end
`endif
        end
      end
      done_d <= done;
    end
  end

  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_run();
  endtask

  task automatic wait_done(input int pa, input int pb, output int lat, output int nb,
                           output logic fb, output logic fd, output logic seen);
    lat = 0; nb = 0; fb = 1'b0; fd = 1'b0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == pa) || (lat == pb);
      if (lat == 1) begin
        fb = busy; fd = done;
      end
      if (busy === 1'b1) nb++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, pass, fail_addr, fail_data, mem_we, mem_re, mem_addr, mem_wdata} !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: got busy=%b done=%b pass=%b we=%b re=%b addr=%0d, want all 0",
                        busy, done, pass, mem_we, mem_re, mem_addr);
    end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_fault_free();
    int lat, nb; logic fb, fd, seen;
    launch();
    wait_done(-1, -1, lat, nb, fb, fd, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL ff_timeout: got no done in 200 cycles, want done"); end
    n_vec++;
    if (lat !== 65 || nb !== 64) begin
      n_err++; $display("FAIL ff_timing: got done at E+%0d busy %0d, want E+65 busy 64", lat, nb);
    end
    n_vec++;
    if (fb !== 1'b1 || mem_we !== 1'b0 || pass !== 1'b1) begin
      n_err++; $display("FAIL ff_status: got first_busy=%b pass=%b we=%b, want 1 1 0", fb, pass, mem_we);
    end
  endtask

  task automatic test_ignore_start();
    int lat, nb; logic fb, fd, seen;
    launch();
    wait_done(10, 40, lat, nb, fb, fd, seen);
    n_vec++;
    if (!seen || lat !== exp_lat + 1 || lat !== 65) begin
      n_err++; $display("FAIL ignore_start: got done at E+%0d (seen=%b), want E+65", lat, seen);
    end
  endtask

  task automatic test_stuck_bit();
    int lat, nb; logic fb, fd, seen;
    stuck1[5] = 4'b0100;
    launch();
    wait_done(-1, -1, lat, nb, fb, fd, seen);
    n_vec++;
    if (!seen || lat !== exp_lat + 1 || nb !== exp_lat) begin
      n_err++; $display("FAIL stuck_timing: got done at E+%0d busy %0d, want E+%0d busy %0d", lat, nb, exp_lat + 1, exp_lat);
    end
    n_vec++;
    if (pass !== 1'b0 || fail_addr !== 4'd5 || fail_data !== 4'b1110) begin
      n_err++; $display("FAIL stuck_result: got pass=%b addr=%0d data=%b, want 0 5 1110", pass, fail_addr, fail_data);
    end
`ifndef BIST_ERR_COUNT_EN
    n_vec++;
    if (lat !== 60) begin n_err++; $display("FAIL stuck_early_done: got E+%0d, want E+60", lat); end
`endif
  endtask

  task automatic test_two_faults();
    int lat, nb; logic fb, fd, seen;
    stuck0[9] = 4'b1111;
    launch();
    wait_done(-1, -1, lat, nb, fb, fd, seen);
    n_vec++;
    if (!seen || lat !== exp_lat + 1) begin
      n_err++; $display("FAIL two_timing: got done at E+%0d, want E+%0d", lat, exp_lat + 1);
    end
    n_vec++;
    if (pass !== 1'b0 || fail_addr !== 4'd9 || fail_data !== 4'b0000) begin
      n_err++; $display("FAIL two_result: got pass=%b addr=%0d data=%b, want 0 9 0000", pass, fail_addr, fail_data);
    end
`ifdef BIST_ERR_COUNT_EN
    n_vec++;
    if (err_count !== 5'd3 || lat !== 65) begin
      n_err++; $display("FAIL two_errcount: got %0d at E+%0d, want 3 at E+65", err_count, lat);
    end
`else
    n_vec++;
    if (lat !== 27) begin n_err++; $display("FAIL two_early_done: got E+%0d, want E+27", lat); end
`endif
  endtask

  task automatic test_reset_midrun();
    int lat, nb; logic fb, fd, seen;
    launch();
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done, pass, fail_addr, fail_data, mem_we, mem_re, mem_addr, mem_wdata} !== 21'd0) begin
      n_err++; $display("FAIL midrun_reset: got busy=%b done=%b we=%b re=%b addr=%0d, want all 0",
                        busy, done, mem_we, mem_re, mem_addr);
    end
`ifdef BIST_ERR_COUNT_EN
    n_vec++;
    if (err_count !== 5'd0) begin n_err++; $display("FAIL midrun_errcount: got %0d, want 0", err_count); end
`endif
    reset = 1'b0;
    bus_q.delete();
    res_q.delete();
    launch();
    wait_done(-1, -1, lat, nb, fb, fd, seen);
    n_vec++;
    if (!seen || lat !== 65 || pass !== 1'b1) begin
      n_err++; $display("FAIL after_reset_run: got done at E+%0d pass=%b, want E+65 pass=1", lat, pass);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic fb, fd, seen;
    stuck1[5] = 4'b0000;
    stuck0[9] = 4'b0000;
    for (int run = 0; run < 2; run++) begin
      launch();
      wait_done(-1, -1, lat, nb, fb, fd, seen);
      n_vec++;
      if (fb !== 1'b1 || fd !== 1'b0) begin
        n_err++; $display("FAIL b2b_restart: got busy=%b done=%b after start, want 1 0", fb, fd);
      end
      n_vec++;
      if (!seen || lat !== 65 || pass !== 1'b1) begin
        n_err++; $display("FAIL b2b_run: got done at E+%0d pass=%b, want E+65 pass=1", lat, pass);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      stuck1[i] = 4'd0;
      stuck0[i] = 4'd0;
    end
    test_reset();
    test_fault_free();
    test_ignore_start();
    test_stuck_bit();
    test_two_faults();
    test_back_to_back();
    test_reset_midrun();
    @(posedge clk); #1;
    n_vec++;
    if (bus_q.size() != 0 || res_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d bus and %0d results left, want 0 0", bus_q.size(), res_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
